sr_flag_arbiter: RTL and testbench
==================================

Name: sr_flag_arbiter

Overview:
- Shared bank of NFLAG set/reset flags, one S/R-flop-style bit per flag.
- Driven by NREQ independent requesters.
- A round-robin arbiter grants at most one requester per cycle; the winner's set/clear command is applied to the addressed flag.
- The invalid S=R=1 case is trapped as a sticky error instead of producing X.
- Sits between control agents and the status-flag storage they share.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NFLAG, 8, number of flags in the bank (1..2^IDXW).
- IDXW, 3, flag index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  per-requester grant; transfer occurs when valid & ready.
- req_idx  in  NREQ*IDXW  packed flag index; requester k uses bits [k*IDXW +: IDXW].
- req_s  in  NREQ  per-requester set bit.
- req_r  in  NREQ  per-requester reset bit.
- flags  out  NFLAG  current flag bank state.
- last_gnt_valid  out  1  a transfer occurred on the previous edge.
- last_gnt_id  out  3  requester id of that transfer.
- err  out  1  sticky error flag.
- err_id  out  3  requester that caused the first error since the last clear.
- err_clr  in  1  clears err and err_id.

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-transfer):
  - flags=0, rr pointer=0, last_gnt_valid=0, last_gnt_id=0, err=0, err_id=0.
  - No command is applied on the edge where rst is low.
- Arbitration is combinational from the registered pointer ptr:
  - Search requesters ptr, ptr+1, ... mod NREQ; the first with req_valid=1 wins.
  - req_ready is one-hot for the winner and all-zero when no requester is valid.
  - req_ready never depends on req_s, req_r or req_idx.
- Pointer update on each rising edge:
  - If a grant was made, ptr <= (winner+1) mod NREQ.
  - If no grant was made, ptr holds.
  - Guarantee: a continuously valid requester is granted within NREQ cycles.
- Command applied on the same edge as the transfer, to flag f = req_idx of the winner:
  - S=0, R=0: f unchanged (transfer still counts, pointer still advances).
  - S=0, R=1: f <= 0.
  - S=1, R=0: f <= 1.
  - S=1, R=1: f unchanged; error event.
  - idx >= NFLAG: no flag changes; error event.
- Latency: updated flags are visible on the flags output the cycle after the transfer (1-cycle latency).
- Only one flag can change per cycle; there are no write collisions.
- Error handling:
  - On an error event with err=0: err <= 1 and err_id <= winner id.
  - While err=1, further error events keep err_id unchanged (first error is kept).
  - err_clr=1 with no error event on that edge: err <= 0, err_id <= 0.
  - err_clr=1 together with an error event: the error wins, so err=1 and err_id = the new winner.
- last_gnt_valid/last_gnt_id are registered and reflect the previous edge's transfer.
  - With no transfer, last_gnt_valid=0 and last_gnt_id holds its previous value.
- Requester protocol:
  - Once valid is raised, the requester holds valid, idx, s and r stable until ready.
  - Withdrawing valid before ready is legal; nothing is applied.
  - The block does not check payload stability.

Test Plan:
1. Reset and single set.
   - Stimulus: assert rst=0 mid-run with flags=8'hFF, then release. Requester 2 sends idx=5, S=1, R=0.
   - Required: flags=8'h00 immediately on reset. req_ready=4'b0100 the same cycle; flags=8'h20 next cycle; last_gnt_id=2.
2. Round-robin fairness.
   - Stimulus: all 4 requesters valid continuously, each setting a distinct flag 0..3, starting from ptr=0.
   - Required: grant order 0,1,2,3; flags=8'h0F after 4 transfers; no requester waits more than 4 cycles.
3. Clear and no-op.
   - Stimulus: from flags=8'hFF, requester 1 sends idx=7, S=0, R=1; then requester 3 sends idx=0, S=0, R=0.
   - Required: flags=8'h7F, then unchanged. Pointer advances after both transfers (next search starts at 0 after requester 3).
4. Invalid S=R=1.
   - Stimulus: requester 0 sends idx=4, S=1, R=1 with flag 4 equal to 1.
   - Required: flag 4 stays 1; err=1, err_id=0 next cycle.
   - Follow-up: requester 2 sends idx=9 (NFLAG=8), an out-of-range index. Required: err_id stays 0.
5. Error clear race.
   - Stimulus: assert err_clr the same cycle requester 3 sends S=1, R=1.
   - Required: err=1, err_id=3.
   - Follow-up: err_clr alone on the next cycle. Required: err=0, err_id=0.
6. Sparse requests.
   - Stimulus: only requester 3 valid, with ptr=1.
   - Required: requester 3 granted immediately, then ptr=0. Idle cycles leave ptr unchanged and last_gnt_valid=0.

Source files
------------

// File: rtl/sr_flag_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sr_flag_arbiter
//  Purpose  : Bank of NFLAG set/reset flags shared by NREQ requesters. A
//             round-robin arbiter picks one requester per cycle and applies
//             its set/clear command to the addressed flag. Illegal commands
//             (S=R=1 or an index past the bank) raise a sticky error that
//             records the first offending requester.
//  Revision : 1.0 - initial release
// ============================================================================
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*IDXW-1:0] req_idx,
    input  logic [NREQ-1:0]      req_s,
    input  logic [NREQ-1:0]      req_r,
    output logic [NFLAG-1:0]     flags,
    output logic                 last_gnt_valid,
    output logic [2:0]           last_gnt_id,
    output logic                 err,
    output logic [2:0]           err_id,
    input  logic                 err_clr
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]       ptr_q;
    logic [2:0]       ptr_d;
    logic [NFLAG-1:0] flags_q;
    logic [NFLAG-1:0] flags_d;
    logic             last_valid_q;
    logic             last_valid_d;
    logic [2:0]       last_id_q;
    logic [2:0]       last_id_d;
    logic             err_q;
    logic             err_d;
    logic [2:0]       err_id_q;
    logic [2:0]       err_id_d;

    // ------------------------------------------------------------------------
    // Arbitration and winner payload
    // ------------------------------------------------------------------------
    logic            w_found;
    logic [2:0]      w_win;
    logic [NREQ-1:0] w_gnt;
    logic [IDXW-1:0] w_idx;
    logic            w_s;
    logic            w_r;
    logic            w_range_err;
    logic            w_sr_err;
    logic            w_err_evt;
    logic            w_cmd_ok;

    // Scan requesters starting at the pointer; the first valid one wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!w_found && req_valid[j] &&
                    (((int'(ptr_q) + i) % NREQ) == j)) begin
                    w_found = 1'b1;
                    w_win   = 3'(j);
                end
            end
        end
    end

    // One-hot grant plus a mux of the winner's command fields.
    always_comb begin
        w_gnt = '0;
        w_idx = '0;
        w_s   = 1'b0;
        w_r   = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            w_gnt[j] = w_found && (w_win == 3'(j));
            if (w_gnt[j]) begin
                w_idx = req_idx[j*IDXW +: IDXW];
                w_s   = req_s[j];
                w_r   = req_r[j];
            end
        end
    end

    assign req_ready = w_gnt;

    // Illegal command classification; either kind blocks the flag write.
    assign w_range_err = (int'(w_idx) >= NFLAG);
    assign w_sr_err    = w_s & w_r;
    assign w_err_evt   = w_found & (w_range_err | w_sr_err);
    assign w_cmd_ok    = w_found & ~w_range_err & ~w_sr_err;

    // ------------------------------------------------------------------------
    // Per-flag next state: only the addressed flag can change in a cycle.
    // ------------------------------------------------------------------------
    for (genvar f = 0; f < NFLAG; f++) begin : g_flag
        logic w_hit;
        assign w_hit = w_cmd_ok && (w_idx == IDXW'(f));
        assign flags_d[f] = !w_hit ? flags_q[f] :
                            w_s    ? 1'b1       :
                            w_r    ? 1'b0       : flags_q[f];
    end

    // Pointer moves just past a winner so it ranks last next time.
    always_comb begin
        ptr_d = ptr_q;
        if (w_found) begin
            ptr_d = (int'(w_win) == NREQ - 1) ? 3'd0 : w_win + 3'd1;
        end
    end

    // Grant history: the id only updates on an actual transfer.
    always_comb begin
        last_valid_d = w_found;
        last_id_d    = w_found ? w_win : last_id_q;
    end

    // Sticky error: first error is kept unless a clear arrives with a new one.
    always_comb begin
        err_d    = err_q;
        err_id_d = err_id_q;
        if (w_err_evt) begin
            if (!err_q || err_clr) begin
                err_d    = 1'b1;
                err_id_d = w_win;
            end
        end else if (err_clr) begin
            err_d    = 1'b0;
            err_id_d = 3'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------

    // Round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 3'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Flag bank storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Previous-edge transfer report.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_valid_q <= 1'b0;
            last_id_q    <= 3'd0;
        end else begin
            last_valid_q <= last_valid_d;
            last_id_q    <= last_id_d;
        end
    end

    // Sticky error status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q    <= 1'b0;
            err_id_q <= 3'd0;
        end else begin
            err_q    <= err_d;
            err_id_q <= err_id_d;
        end
    end

    assign flags          = flags_q;
    assign last_gnt_valid = last_valid_q;
    assign last_gnt_id    = last_id_q;
    assign err            = err_q;
    assign err_id         = err_id_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_flag_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_flag_arbiter
//  Purpose  : Self-checking bench for sr_flag_arbiter: directed scenarios
//             plus randomized traffic checked against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sr_flag_arbiter;

    localparam int NREQ  = 4;
    localparam int NFLAG = 8;
    localparam int IDXW  = 4;   // wide enough to address past the bank

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NREQ-1:0]      req_s;
    logic [NREQ-1:0]      req_r;
    logic [NFLAG-1:0]     flags;
    logic                 last_gnt_valid;
    logic [2:0]           last_gnt_id;
    logic                 err;
    logic [2:0]           err_id;
    logic                 err_clr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_idx        (req_idx),
        .req_s          (req_s),
        .req_r          (req_r),
        .flags          (flags),
        .last_gnt_valid (last_gnt_valid),
        .last_gnt_id    (last_gnt_id),
        .err            (err),
        .err_id         (err_id),
        .err_clr        (err_clr)
    );

    // ------------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------------
    logic [NFLAG-1:0] m_flags;
    int               m_ptr;
    logic             m_last_valid;
    int               m_last_id;
    logic             m_err;
    int               m_err_id;

    task automatic m_reset();
        m_flags = '0; m_ptr = 0; m_last_valid = 1'b0; m_last_id = 0;
        m_err = 1'b0; m_err_id = 0;
    endtask

    function automatic int m_winner();
        for (int k = 0; k < NREQ; k++) begin
            int c = (m_ptr + k) % NREQ;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] m_ready();
        int w = m_winner();
        logic [NREQ-1:0] v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    task automatic m_clock();
        int  w = m_winner();
        int  idx;
        bit  evt = 1'b0;
        if (w >= 0) begin
            idx = int'(req_idx[w*IDXW +: IDXW]);
            evt = (req_s[w] && req_r[w]) || (idx >= NFLAG);
            if (!evt) begin
                if (req_s[w])      m_flags[idx] = 1'b1;
                else if (req_r[w]) m_flags[idx] = 1'b0;
            end
        end
        if (evt) begin
            if (!m_err || err_clr) begin m_err = 1'b1; m_err_id = w; end
        end else if (err_clr) begin
            m_err = 1'b0; m_err_id = 0;
        end
        m_last_valid = (w >= 0);
        if (w >= 0) begin
            m_last_id = w;
            m_ptr     = (w + 1) % NREQ;
        end
    endtask

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic idle();
        req_valid = '0; req_s = '0; req_r = '0; req_idx = '0;
    endtask

    task automatic set_req(input int k, input int idx, input bit s, input bit r);
        req_valid[k]          = 1'b1;
        req_idx[k*IDXW +: IDXW] = IDXW'(idx);
        req_s[k]              = s;
        req_r[k]              = r;
    endtask

    // Clock edge with the model stepped in lock-step; returns 1 unit later.
    task automatic tick();
        @(posedge clk);
        if (rst) m_clock();
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        idle(); err_clr = 1'b0; rst = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b1; m_reset();
        #1;
        checks++; if (flags !== 8'h00) begin errors++; $display("FAIL reset_flags got=%h exp=00", flags); end
        checks++; if (last_gnt_valid !== 1'b0 || last_gnt_id !== 3'd0) begin errors++; $display("FAIL reset_last got=%b/%0d exp=0/0", last_gnt_valid, last_gnt_id); end
        checks++; if (err !== 1'b0 || err_id !== 3'd0) begin errors++; $display("FAIL reset_err got=%b/%0d exp=0/0", err, err_id); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        // Fill the bank so the asynchronous reset is visible.
        for (int i = 0; i < NFLAG; i++) begin
            idle(); set_req(i % NREQ, i, 1'b1, 1'b0); tick();
        end
        idle();
        checks++; if (flags !== 8'hFF) begin errors++; $display("FAIL fill_ff got=%h exp=ff", flags); end
        // Asynchronous reset mid-cycle with a pending command.
        #2; rst = 1'b0; set_req(0, 0, 1'b0, 1'b1); m_reset();
        #1;
        checks++; if (flags !== 8'h00) begin errors++; $display("FAIL async_reset got=%h exp=00", flags); end
        @(posedge clk); #1;
        checks++; if (flags !== 8'h00 || last_gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_edge_no_cmd got=%h/%b exp=00/0", flags, last_gnt_valid); end
        idle(); rst = 1'b1;
        set_req(2, 5, 1'b1, 1'b0); #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        tick(); idle();
        checks++; if (flags !== 8'h20) begin errors++; $display("FAIL single_flags got=%h exp=20", flags); end
        checks++; if (last_gnt_valid !== 1'b1 || last_gnt_id !== 3'd2) begin errors++; $display("FAIL single_last got=%b/%0d exp=1/2", last_gnt_valid, last_gnt_id); end
    endtask

    task automatic test_round_robin();
        int wait_cnt [NREQ];
        int max_wait = 0;
        #1; rst = 1'b0; #1; rst = 1'b1; m_reset();
        idle();
        for (int k = 0; k < NREQ; k++) set_req(k, k, 1'b1, 1'b0);
        for (int n = 0; n < NREQ; n++) begin
            #1;
            checks++; if (req_ready !== 4'(1 << n)) begin errors++; $display("FAIL rr_order step=%0d got=%b exp=%b", n, req_ready, 4'(1 << n)); end
            tick();
        end
        checks++; if (flags !== 8'h0F) begin errors++; $display("FAIL rr_flags got=%h exp=0f", flags); end
        for (int k = 0; k < NREQ; k++) wait_cnt[k] = 0;
        for (int n = 0; n < 2 * NREQ; n++) begin
            #1;
            for (int k = 0; k < NREQ; k++) begin
                if (req_ready[k]) wait_cnt[k] = 0;
                else begin
                    wait_cnt[k]++;
                    if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
                end
            end
            tick();
        end
        idle();
        checks++; if (max_wait >= NREQ) begin errors++; $display("FAIL rr_max_wait got=%0d exp<%0d", max_wait, NREQ); end
    endtask

    task automatic test_clear_noop();
        for (int i = 4; i < NFLAG; i++) begin
            idle(); set_req(i % NREQ, i, 1'b1, 1'b0); tick();
        end
        idle();
        checks++; if (flags !== 8'hFF) begin errors++; $display("FAIL clr_pre got=%h exp=ff", flags); end
        set_req(1, 7, 1'b0, 1'b1); #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL clr_ready got=%b exp=0010", req_ready); end
        tick(); idle();
        checks++; if (flags !== 8'h7F) begin errors++; $display("FAIL clr_flags got=%h exp=7f", flags); end
        set_req(3, 0, 1'b0, 1'b0); tick(); idle();
        checks++; if (flags !== 8'h7F || last_gnt_id !== 3'd3 || last_gnt_valid !== 1'b1) begin errors++; $display("FAIL noop got=%h/%b/%0d exp=7f/1/3", flags, last_gnt_valid, last_gnt_id); end
        req_valid = 4'b1111; #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL noop_ptr got=%b exp=0001", req_ready); end
        idle();
    endtask

    task automatic test_invalid_sr();
        set_req(0, 4, 1'b1, 1'b1); #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL sr_ready got=%b exp=0001", req_ready); end
        tick(); idle();
        checks++; if (flags !== 8'h7F) begin errors++; $display("FAIL sr_flags got=%h exp=7f", flags); end
        checks++; if (err !== 1'b1 || err_id !== 3'd0) begin errors++; $display("FAIL sr_err got=%b/%0d exp=1/0", err, err_id); end
        set_req(2, 9, 1'b1, 1'b0); #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL range_ready got=%b exp=0100", req_ready); end
        tick(); idle();
        checks++; if (err !== 1'b1 || err_id !== 3'd0 || flags !== 8'h7F) begin errors++; $display("FAIL range_err got=%b/%0d/%h exp=1/0/7f", err, err_id, flags); end
    endtask

    task automatic test_err_clr_race();
        set_req(3, 2, 1'b1, 1'b1); err_clr = 1'b1; tick(); idle();
        checks++; if (err !== 1'b1 || err_id !== 3'd3) begin errors++; $display("FAIL race_err got=%b/%0d exp=1/3", err, err_id); end
        tick(); err_clr = 1'b0;
        checks++; if (err !== 1'b0 || err_id !== 3'd0) begin errors++; $display("FAIL clr_err got=%b/%0d exp=0/0", err, err_id); end
        checks++; if (last_gnt_valid !== 1'b0 || last_gnt_id !== 3'd3) begin errors++; $display("FAIL clr_last got=%b/%0d exp=0/3", last_gnt_valid, last_gnt_id); end
    endtask

    task automatic test_sparse();
        set_req(0, 0, 1'b0, 1'b0); tick(); idle();   // pointer now 1
        set_req(3, 1, 1'b0, 1'b0); #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL sparse_ready got=%b exp=1000", req_ready); end
        tick(); idle();
        checks++; if (last_gnt_valid !== 1'b1 || last_gnt_id !== 3'd3) begin errors++; $display("FAIL sparse_last got=%b/%0d exp=1/3", last_gnt_valid, last_gnt_id); end
        repeat (2) begin
            tick();
            checks++; if (last_gnt_valid !== 1'b0 || last_gnt_id !== 3'd3) begin errors++; $display("FAIL idle_last got=%b/%0d exp=0/3", last_gnt_valid, last_gnt_id); end
        end
        req_valid = 4'b1111; #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL sparse_ptr got=%b exp=0001", req_ready); end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NREQ; k++) begin
                req_valid[k]            = ($urandom_range(0, 2) != 0);
                req_idx[k*IDXW +: IDXW] = IDXW'($urandom_range(0, 9));
                req_s[k]                = 1'($urandom_range(0, 1));
                req_r[k]                = 1'($urandom_range(0, 1));
            end
            err_clr = ($urandom_range(0, 7) == 0);
            #1;
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b0; m_reset(); #1;
                checks++; if (flags !== m_flags || err !== m_err) begin errors++; $display("FAIL rnd_reset got=%h/%b exp=%h/%b", flags, err, m_flags, m_err); end
                rst = 1'b1;
            end
            checks++; if (req_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, req_ready, m_ready()); end
            tick();
            checks++; if (flags !== m_flags) begin errors++; $display("FAIL rnd_flags n=%0d got=%h exp=%h", n, flags, m_flags); end
            checks++; if (err !== m_err || err_id !== 3'(m_err_id)) begin errors++; $display("FAIL rnd_err n=%0d got=%b/%0d exp=%b/%0d", n, err, err_id, m_err, m_err_id); end
            checks++; if (last_gnt_valid !== m_last_valid || last_gnt_id !== 3'(m_last_id)) begin errors++; $display("FAIL rnd_last n=%0d got=%b/%0d exp=%b/%0d", n, last_gnt_valid, last_gnt_id, m_last_valid, m_last_id); end
        end
        idle(); err_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_clear_noop();
        test_invalid_sr();
        test_err_clr_race();
        test_sparse();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
